// File: rtl/ysyx_25040129_wbu.sv
// Writeback unit: arbitrates LSU/EXU results onto one registered
// register-file write port and keeps per-register pending-write counters
// so that decode can stall on RAW/WAW hazards.
module ysyx_25040129_wbu #(
   parameter int REGS_DIG = 4,
   parameter int XLEN     = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                iss_valid_i,
   input  logic [REGS_DIG-1:0] iss_rd_i,
   output logic                iss_ready_o,
   input  logic [REGS_DIG-1:0] src1_id_i,
   input  logic [REGS_DIG-1:0] src2_id_i,
   output logic                src1_busy_o,
   output logic                src2_busy_o,
   input  logic                exu_valid_i,
   output logic                exu_ready_o,
   input  logic [REGS_DIG-1:0] exu_rd_i,
   input  logic [XLEN-1:0]     exu_data_i,
   input  logic                lsu_valid_i,
   output logic                lsu_ready_o,
   input  logic [REGS_DIG-1:0] lsu_rd_i,
   input  logic [XLEN-1:0]     lsu_data_i,
   output logic [REGS_DIG-1:0] rd_o,
   output logic                reg_write_o,
   output logic [XLEN-1:0]     result_o
);

   localparam int NREGS = 1 << REGS_DIG;

   // x0 never gets a counter; it is hardwired to zero.
   logic [1:0]          pend_q [1:NREGS-1];
   logic [REGS_DIG-1:0] rd_q,        rd_d;
   logic [XLEN-1:0]     result_q,    result_d;
   logic                reg_write_q, reg_write_d;

   logic                acc;
   logic [REGS_DIG-1:0] acc_rd;
   logic [XLEN-1:0]     acc_data;
   logic                iss_fire;
   logic [NREGS-1:1]    inc_vec;
   logic [NREGS-1:1]    dec_vec;

   // LSU always wins; EXU only sees ready when the LSU is idle.
   assign lsu_ready_o = 1'b1;
   assign exu_ready_o = !lsu_valid_i;
   assign acc         = lsu_valid_i || exu_valid_i;
   assign acc_rd      = lsu_valid_i ? lsu_rd_i   : exu_rd_i;
   assign acc_data    = lsu_valid_i ? lsu_data_i : exu_data_i;
   assign iss_fire    = iss_valid_i && iss_ready_o;

   // Scoreboard lookups and per-register increment/decrement strobes.
   always_comb begin
      iss_ready_o = 1'b1;
      src1_busy_o = 1'b0;
      src2_busy_o = 1'b0;
      inc_vec     = '0;
      dec_vec     = '0;
      for (int i = 1; i < NREGS; i++) begin
         if (iss_rd_i == REGS_DIG'(i) && pend_q[i] == 2'd3) iss_ready_o = 1'b0;
         if (src1_id_i == REGS_DIG'(i) && pend_q[i] != 2'd0) src1_busy_o = 1'b1;
         if (src2_id_i == REGS_DIG'(i) && pend_q[i] != 2'd0) src2_busy_o = 1'b1;
         inc_vec[i] = iss_fire && (iss_rd_i == REGS_DIG'(i));
         dec_vec[i] = reg_write_q && (rd_q == REGS_DIG'(i));
      end
   end

   // Next state of the write port; rd/result hold when nothing is accepted.
   always_comb begin
      rd_d        = rd_q;
      result_d    = result_q;
      reg_write_d = 1'b0;
      if (acc) begin
         rd_d        = acc_rd;
         result_d    = acc_data;
         reg_write_d = (acc_rd != '0);
      end
   end

   // Write-port registers and pending counters; retire on the RF capture edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_q        <= '0;
         result_q    <= '0;
         reg_write_q <= 1'b0;
         for (int i = 1; i < NREGS; i++) pend_q[i] <= 2'd0;
      end else begin
         rd_q        <= rd_d;
         result_q    <= result_d;
         reg_write_q <= reg_write_d;
         for (int i = 1; i < NREGS; i++) begin
            if (inc_vec[i] && !dec_vec[i]) begin
               pend_q[i] <= pend_q[i] + 2'd1;
            end else if (dec_vec[i] && !inc_vec[i] && pend_q[i] != 2'd0) begin
               pend_q[i] <= pend_q[i] - 2'd1;
            end
         end
      end
   end

`ifndef SYNTHESIS
   // Retiring a register with no pending write means upstream broke protocol.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int i = 1; i < NREGS; i++) begin
            if (dec_vec[i] && !inc_vec[i] && pend_q[i] == 2'd0)
               $error("wbu: retire of x%0d with no pending write", i);
         end
      end
   end
`endif

   assign rd_o        = rd_q;
   assign result_o    = result_q;
   assign reg_write_o = reg_write_q;

endmodule
